// File: rtl/ln_mac_bf16_pkg.sv
// Shared types and BF16 constants for the ln_mac_bf16 natural-log block.
// Optional rounding in the top is selected with `define LN_ROUND_EN.
package ln_bf16_pkg;

    localparam logic [15:0] QNAN = 16'h7FC0;
    localparam logic [15:0] NINF = 16'hFF80;
    localparam logic [15:0] PINF = 16'h7F80;

    typedef enum logic [1:0] {UNCFG, RUN, DRAIN} ln_state_e;

    typedef enum logic [2:0] {NORM, ZERO, NEG, INF, NAN} ln_class_e;

    typedef struct packed {
        logic [15:0] base;
        logic [15:0] offset;
    } ln_entry_t;

    // Priority: NaN, negative non-zero, zero/denormal, +inf, normal.
    function automatic ln_class_e classify(input logic [15:0] v);
        if (v[14:7] == 8'hFF && v[6:0] != 7'd0) return NAN;
        else if (v[15] && v[14:0] != 15'd0)     return NEG;
        else if (v[14:7] == 8'h00)              return ZERO;
        else if (v[14:7] == 8'hFF)              return INF;
        else                                    return NORM;
    endfunction

endpackage

// File: rtl/ln_mac_bf16_if.sv
// Config, status and streaming signals of ln_mac_bf16; slave = block side.
interface ln_mac_bf16_if #(parameter int AW = 4) ();

    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [31:0]     cfg_data;
    logic            cfg_commit;
    logic            cfg_unlock;
    logic            cfg_err;
    logic            busy;

    // A beat moves on a clock edge where valid and ready are both high;
    // valid never waits for ready, and the payload holds while valid is unacknowledged.
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     x;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     y;
    logic            y_oor;

    ln_bf16_pkg::ln_state_e dbg_state;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_commit, cfg_unlock,
        input  in_valid, x, out_ready,
        output cfg_err, busy, in_ready, out_valid, y, y_oor, dbg_state
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_commit, cfg_unlock,
        output in_valid, x, out_ready,
        input  cfg_err, busy, in_ready, out_valid, y, y_oor, dbg_state
    );

endinterface

// File: rtl/ln_mac_bf16_coef_rf.sv
// Coefficient register file: N_SEG entries, one synchronous write, one combinational read.
module ln_coef_rf
    import ln_bf16_pkg::*;
#(
    parameter int N_SEG = 16,
    parameter int AW    = $clog2(N_SEG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  ln_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output ln_entry_t     rdata_o
);

    ln_entry_t mem_q [N_SEG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SEG; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ln_mac_bf16.sv
// Pipelined BF16 ln(x): per-exponent linear segment y = base + (M*offset >>> 7).
// Define LN_ROUND_EN to round the in-range product half-up instead of truncating.
module ln_mac_bf16
    import ln_bf16_pkg::*;
#(
    parameter int N_SEG = 16,
    parameter int E_LO  = 120
) (
    input  logic          clk,
    input  logic          rst,
    ln_mac_bf16_if.slave  bus
);

    localparam int AW   = $clog2(N_SEG);
    localparam int E_HI = E_LO + N_SEG - 1;

    ln_state_e state_q, state_d;
    logic      cfg_err_q, cfg_err_d;
    logic      rf_we, adv, accept, drained;

    logic [7:0]    x_e, x_rel;
    logic          x_lo, x_hi;
    logic [AW-1:0] x_idx;
    ln_entry_t     rd_ent;

    logic            s1_v_q, s1_lo_q, s1_hi_q;
    ln_class_e       s1_cls_q;
    logic [6:0]      s1_m_q;
    ln_entry_t       s1_ent_q;
    logic signed [23:0] prod;

    logic            s2_v_q, s2_lo_q, s2_hi_q;
    ln_class_e       s2_cls_q;
    logic [15:0]     s2_base_q, s2_off_q;
    logic [23:0]     s2_p_q, p_adj;

    logic            out_valid_q, y_oor_q, oor_d;
    logic [15:0]     y_q, y_d;

    assign adv     = !out_valid_q || bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;
    assign drained = !s1_v_q && !s2_v_q && !out_valid_q;

    // Decode and table index, clamped to the end entries when out of range.
    assign x_e   = bus.x[14:7];
    assign x_lo  = x_e < 8'(E_LO);
    assign x_hi  = x_e > 8'(E_HI);
    assign x_rel = x_e - 8'(E_LO);
    assign x_idx = x_lo ? '0 : (x_hi ? AW'(N_SEG - 1) : x_rel[AW-1:0]);

    ln_coef_rf #(.N_SEG(N_SEG), .AW(AW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rf_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (x_idx),
        .rdata_o (rd_ent)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UNCFG;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_err_d = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            UNCFG: begin
                rf_we = bus.cfg_we;
                if (bus.cfg_commit) state_d = RUN;
            end
            RUN: begin
                cfg_err_d = bus.cfg_we || bus.cfg_commit;
                if (bus.cfg_unlock) state_d = DRAIN;
            end
            DRAIN: begin
                cfg_err_d = bus.cfg_we || bus.cfg_commit;
                if (drained) state_d = UNCFG;
            end
            default: state_d = UNCFG;
        endcase
    end

    assign prod = $signed(s1_ent_q.offset) * $signed({1'b0, s1_m_q});

    always_comb begin
        p_adj = s2_p_q;
`ifdef LN_ROUND_EN
        p_adj = s2_p_q + 24'd64;
`else
        p_adj = s2_p_q;
`endif
        y_d   = s2_base_q + p_adj[22:7];
        oor_d = 1'b0;
        case (s2_cls_q)
            NAN, NEG: y_d = QNAN;
            ZERO:     y_d = NINF;
            INF:      y_d = PINF;
            default: begin
                if (s2_lo_q) begin
                    y_d   = s2_base_q;
                    oor_d = 1'b1;
                end else if (s2_hi_q) begin
                    y_d   = s2_base_q + s2_off_q;
                    oor_d = 1'b1;
                end
            end
        endcase
    end

    // Every stage moves together on adv, so a stalled output freezes the whole pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q      <= 1'b0;
            s1_lo_q     <= 1'b0;
            s1_hi_q     <= 1'b0;
            s1_cls_q    <= NORM;
            s1_m_q      <= '0;
            s1_ent_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_lo_q     <= 1'b0;
            s2_hi_q     <= 1'b0;
            s2_cls_q    <= NORM;
            s2_base_q   <= '0;
            s2_off_q    <= '0;
            s2_p_q      <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_oor_q     <= 1'b0;
        end else if (adv) begin
            s1_v_q <= accept;
            if (accept) begin
                s1_lo_q  <= x_lo;
                s1_hi_q  <= x_hi;
                s1_cls_q <= classify(bus.x);
                s1_m_q   <= bus.x[6:0];
                s1_ent_q <= rd_ent;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_lo_q   <= s1_lo_q;
                s2_hi_q   <= s1_hi_q;
                s2_cls_q  <= s1_cls_q;
                s2_base_q <= s1_ent_q.base;
                s2_off_q  <= s1_ent_q.offset;
                s2_p_q    <= prod;
            end
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                y_q     <= y_d;
                y_oor_q <= oor_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == RUN) && adv;
    assign bus.busy      = (state_q != UNCFG);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_oor     = y_oor_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ln_mac_bf16.sv
// Self-checking bench for ln_mac_bf16 with a behavioural integer reference model.
`timescale 1ns/1ps
module tb_ln_mac_bf16;
  import ln_bf16_pkg::*;

  localparam int N_SEG = 16;
  localparam int E_LO  = 120;
  localparam int E_HI  = E_LO + N_SEG - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ln_mac_bf16_if #(.AW(4)) bus ();

  ln_mac_bf16 #(.N_SEG(N_SEG), .E_LO(E_LO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [15:0] m_base [N_SEG];
  logic [15:0] m_off  [N_SEG];

  function automatic void model(input logic [15:0] xv, output logic [15:0] ey, output logic eoor);
    int e, m, p, q, idx;
    e = int'(xv[14:7]);
    m = int'(xv[6:0]);
    eoor = 1'b0;
    if (e == 255 && m != 0)            ey = 16'h7FC0;
    else if (xv[15] && xv[14:0] != 0)  ey = 16'h7FC0;
    else if (e == 0)                   ey = 16'hFF80;
    else if (e == 255)                 ey = 16'h7F80;
    else if (e < E_LO) begin
      ey = m_base[0];
      eoor = 1'b1;
    end else if (e > E_HI) begin
      ey = 16'(m_base[N_SEG-1] + m_off[N_SEG-1]);
      eoor = 1'b1;
    end else begin
      idx = e - E_LO;
      p = int'($signed(m_off[idx])) * m;
`ifdef LN_ROUND_EN
      p = p + 64;
`endif
      q = p >>> 7;
      ey = 16'(int'(m_base[idx]) + q);
    end
  endfunction

  function automatic logic [15:0] rand_x();
    logic [7:0] e;
    logic [6:0] m;
    logic s;
    e = 8'($urandom_range(E_LO - 3, E_HI + 3));
    m = 7'($urandom_range(0, 127));
    s = ($urandom_range(0, 7) == 0);
    return {s, e, m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int a, input logic [15:0] b, input logic [15:0] o, input bit cm);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'(a);
    bus.cfg_data = {b, o};
    bus.cfg_commit = cm;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  // Only used when the block is expected to be in UNCFG, so the write must land.
  task automatic load(input int a, input logic [15:0] b, input logic [15:0] o, input bit cm);
    cfg_write(a, b, o, cm);
    m_base[a] = b;
    m_off[a] = o;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  task automatic pulse_unlock();
    @(negedge clk);
    bus.cfg_unlock = 1'b1;
    @(negedge clk);
    bus.cfg_unlock = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stream driver / collector ----------------
  logic [15:0] in_q [$];
  logic [15:0] got_y_q [$];
  logic        got_oor_q [$];
  int          got_seen_q [$];
  int          acc_cyc_q [$];
  int          stall_bad;

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1
  task automatic run_stream(input int n_exp, input int rmode, input int budget);
    int start, k, first_seen;
    bit pend;
    logic [15:0] py;
    logic poor;
    got_y_q.delete();
    got_oor_q.delete();
    got_seen_q.delete();
    acc_cyc_q.delete();
    stall_bad = 0;
    pend = 1'b0;
    py = '0;
    poor = 1'b0;
    k = 0;
    first_seen = 0;
    start = cyc;
    while (got_y_q.size() < n_exp && (cyc - start) < budget) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (pend) begin
          if (bus.y !== py || bus.y_oor !== poor) stall_bad++;
        end else begin
          first_seen = cyc;
        end
      end
      bus.out_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      bus.in_valid = (in_q.size() > 0);
      bus.x = (in_q.size() > 0) ? in_q[0] : 16'h0000;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        void'(in_q.pop_front());
        acc_cyc_q.push_back(cyc);
      end
      pend = bus.out_valid && !bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        got_y_q.push_back(bus.y);
        got_oor_q.push_back(bus.y_oor);
        got_seen_q.push_back(first_seen);
      end
      py = bus.y;
      poor = bus.y_oor;
      k++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  logic        exp_oor_q [$];

  task automatic push_model(input logic [15:0] xv);
    logic [15:0] ey;
    logic eo;
    model(xv, ey, eo);
    in_q.push_back(xv);
    exp_q.push_back(ey);
    exp_oor_q.push_back(eo);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.cfg_commit = 0;
    bus.cfg_unlock = 0; bus.in_valid = 0; bus.x = 0; bus.out_ready = 1;
    for (int i = 0; i < N_SEG; i++) begin m_base[i] = 0; m_off[i] = 0; end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h exp=0000", bus.y); end
    total++; if (bus.y_oor !== 1'b0) begin bad++; $display("FAIL reset_y_oor got=%0b exp=0", bus.y_oor); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%0b exp=0", bus.cfg_err); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    total++; if (bus.dbg_state !== UNCFG) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, UNCFG); end
  endtask

  task automatic test_special_values();
    for (int i = 0; i < N_SEG; i++) begin
      if (i == 8) load(8, 16'h3F31, 16'h005A, 1'b0);
      else load(i, 16'($urandom), 16'($urandom), 1'b0);
    end
    pulse_commit();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL commit_busy got=%0b exp=1", bus.busy); end
    total++; if (bus.dbg_state !== RUN) begin bad++; $display("FAIL commit_state got=%0d exp=%0d", bus.dbg_state, RUN); end
    in_q = '{16'h4000, 16'h4040};
    run_stream(2, 0, 40);
    total++; if (got_y_q.size() != 2) begin bad++; $display("FAIL sv_count got=%0d exp=2", got_y_q.size()); end
    if (got_y_q.size() == 2) begin
      total++; if (got_y_q[0] !== 16'h3F31) begin bad++; $display("FAIL sv_y0 got=%h exp=3f31", got_y_q[0]); end
      total++; if (got_oor_q[0] !== 1'b0) begin bad++; $display("FAIL sv_oor0 got=%0b exp=0", got_oor_q[0]); end
      total++; if (got_y_q[1] !== 16'h3F5E) begin bad++; $display("FAIL sv_y1 got=%h exp=3f5e", got_y_q[1]); end
      total++; if (got_seen_q[0] - acc_cyc_q[0] != 3) begin bad++; $display("FAIL sv_latency got=%0d exp=3", got_seen_q[0] - acc_cyc_q[0]); end
    end
  endtask

  task automatic test_specials();
    logic [15:0] xs [5];
    logic [15:0] ys [5];
    xs = '{16'h0000, 16'h0001, 16'hBF80, 16'h7F80, 16'h7FC1};
    ys = '{16'hFF80, 16'hFF80, 16'h7FC0, 16'h7F80, 16'h7FC0};
    in_q.delete();
    for (int i = 0; i < 5; i++) in_q.push_back(xs[i]);
    run_stream(5, 0, 40);
    total++; if (got_y_q.size() != 5) begin bad++; $display("FAIL spec_count got=%0d exp=5", got_y_q.size()); end
    for (int i = 0; i < got_y_q.size() && i < 5; i++) begin
      total++; if (got_y_q[i] !== ys[i] || got_oor_q[i] !== 1'b0) begin
        bad++; $display("FAIL spec_y[%0d] x=%h got=%h/%0b exp=%h/0", i, xs[i], got_y_q[i], got_oor_q[i], ys[i]);
      end
    end
    if (acc_cyc_q.size() == 5) begin
      total++; if (acc_cyc_q[4] - acc_cyc_q[0] != 4) begin bad++; $display("FAIL spec_throughput got=%0d exp=4", acc_cyc_q[4] - acc_cyc_q[0]); end
    end
  endtask

  task automatic test_out_of_range();
    in_q.delete(); exp_q.delete(); exp_oor_q.delete();
    push_model(16'h3A00);
    push_model(16'h4400);
    for (int i = 0; i < 30; i++) push_model(($urandom_range(0, 5) == 0) ? 16'($urandom) : rand_x());
    total++; if (exp_oor_q[0] !== 1'b1 || exp_q[0] !== m_base[0]) begin bad++; $display("FAIL oor_model_lo got=%h exp=%h", exp_q[0], m_base[0]); end
    run_stream(exp_q.size(), 0, 200);
    total++; if (got_y_q.size() != exp_q.size()) begin bad++; $display("FAIL oor_count got=%0d exp=%0d", got_y_q.size(), exp_q.size()); end
    for (int i = 0; i < got_y_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_y_q[i] !== exp_q[i] || got_oor_q[i] !== exp_oor_q[i]) begin
        bad++; $display("FAIL oor_y[%0d] got=%h/%0b exp=%h/%0b", i, got_y_q[i], got_oor_q[i], exp_q[i], exp_oor_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    in_q.delete(); exp_q.delete(); exp_oor_q.delete();
    for (int i = 0; i < 6; i++) push_model(rand_x());
    run_stream(6, 1, 200);
    total++; if (got_y_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", got_y_q.size()); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable_cycles exp=0", stall_bad); end
    for (int i = 0; i < got_y_q.size() && i < 6; i++) begin
      total++; if (got_y_q[i] !== exp_q[i] || got_oor_q[i] !== exp_oor_q[i]) begin
        bad++; $display("FAIL bp_y[%0d] got=%h/%0b exp=%h/%0b", i, got_y_q[i], got_oor_q[i], exp_q[i], exp_oor_q[i]);
      end
    end
  endtask

  task automatic test_cfg_protect();
    logic [15:0] v [3];
    cfg_write(8, 16'h1234, 16'h0777, 1'b0);
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL prot_err_we got=%0b exp=1", bus.cfg_err); end
    @(negedge clk);
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL prot_err_pulse got=%0b exp=0", bus.cfg_err); end
    pulse_commit();
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL prot_err_commit got=%0b exp=1", bus.cfg_err); end
    in_q = '{16'h4000};
    run_stream(1, 0, 20);
    total++; if (got_y_q.size() != 1 || got_y_q[0] !== 16'h3F31) begin bad++; $display("FAIL prot_table got=%h exp=3f31", (got_y_q.size() > 0) ? got_y_q[0] : 16'hxxxx); end

    // Unlock with three beats stuck behind a stalled output.
    exp_q.delete(); exp_oor_q.delete(); in_q.delete();
    for (int i = 0; i < 3; i++) begin
      v[i] = rand_x();
      push_model(v[i]);
    end
    in_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.x = v[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_unlock = 1'b1;
    @(negedge clk);
    bus.cfg_unlock = 1'b0;
    total++; if (bus.dbg_state !== DRAIN) begin bad++; $display("FAIL drain_state got=%0d exp=%0d", bus.dbg_state, DRAIN); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready got=%0b exp=0", bus.in_ready); end
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL drain_hold busy=%0b out_valid=%0b exp=1/1", bus.busy, bus.out_valid); end
    run_stream(3, 0, 30);
    total++; if (got_y_q.size() != 3) begin bad++; $display("FAIL drain_count got=%0d exp=3", got_y_q.size()); end
    for (int i = 0; i < got_y_q.size() && i < 3; i++) begin
      total++; if (got_y_q[i] !== exp_q[i]) begin bad++; $display("FAIL drain_y[%0d] got=%h exp=%h", i, got_y_q[i], exp_q[i]); end
    end
    wait_idle(5);
    total++; if (bus.busy !== 1'b0 || bus.dbg_state !== UNCFG) begin bad++; $display("FAIL drain_done busy=%0b state=%0d exp=0/%0d", bus.busy, bus.dbg_state, UNCFG); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL uncfg_in_ready got=%0b exp=0", bus.in_ready); end

    pulse_unlock();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL unlock_ignored busy=%0b exp=0", bus.busy); end

    // Write and commit in the same cycle: the write lands, then RUN.
    load(9, 16'($urandom), 16'($urandom), 1'b1);
    total++; if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0) begin bad++; $display("FAIL we_commit busy=%0b err=%0b exp=1/0", bus.busy, bus.cfg_err); end
    exp_q.delete(); exp_oor_q.delete(); in_q.delete();
    push_model({9'h081, 7'($urandom_range(0, 127))});
    run_stream(1, 0, 20);
    total++; if (got_y_q.size() != 1 || got_y_q[0] !== exp_q[0]) begin bad++; $display("FAIL we_commit_y got=%h exp=%h", (got_y_q.size() > 0) ? got_y_q[0] : 16'hxxxx, exp_q[0]); end

    // cfg_we during the single DRAIN cycle of an empty pipeline.
    @(negedge clk);
    bus.cfg_unlock = 1'b1;
    @(negedge clk);
    bus.cfg_unlock = 1'b0;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 4'd8;
    bus.cfg_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    total++; if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL drain_we err=%0b busy=%0b exp=1/0", bus.cfg_err, bus.busy); end
    pulse_commit();
    in_q = '{16'h4000};
    run_stream(1, 0, 20);
    total++; if (got_y_q.size() != 1 || got_y_q[0] !== 16'h3F31) begin bad++; $display("FAIL drain_we_table got=%h exp=3f31", (got_y_q.size() > 0) ? got_y_q[0] : 16'hxxxx); end
  endtask

  task automatic test_round();
    logic [15:0] b, ey;
    pulse_unlock();
    wait_idle(10);
    b = 16'($urandom_range(0, 16'hFFFE));
    load(8, b, 16'h0001, 1'b0);
    pulse_commit();
`ifdef LN_ROUND_EN
    ey = b + 16'd1;
`else
    ey = b;
`endif
    in_q = '{16'h407F};
    run_stream(1, 0, 20);
    total++; if (got_y_q.size() != 1 || got_y_q[0] !== ey || got_oor_q[0] !== 1'b0) begin
      bad++; $display("FAIL round_y got=%h exp=%h", (got_y_q.size() > 0) ? got_y_q[0] : 16'hxxxx, ey);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.x = rand_x();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid out_valid=%0b busy=%0b exp=0/0", bus.out_valid, bus.busy); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N_SEG; i++) begin m_base[i] = 0; m_off[i] = 0; end
    pulse_commit();
    exp_q.delete(); exp_oor_q.delete(); in_q.delete();
    push_model(16'h4040);
    push_model(16'h3A00);
    push_model(rand_x());
    run_stream(3, 0, 30);
    total++; if (got_y_q.size() != 3) begin bad++; $display("FAIL rst_mid_count got=%0d exp=3", got_y_q.size()); end
    for (int i = 0; i < got_y_q.size() && i < 3; i++) begin
      total++; if (got_y_q[i] !== exp_q[i] || got_oor_q[i] !== exp_oor_q[i]) begin
        bad++; $display("FAIL rst_mid_y[%0d] got=%h/%0b exp=%h/%0b", i, got_y_q[i], got_oor_q[i], exp_q[i], exp_oor_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_special_values();
    test_specials();
    test_out_of_range();
    test_backpressure();
    test_cfg_protect();
    test_round();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
